// File: rtl/fpaddsub_pkg.sv
// Shared constants and bundle type for the FP add/sub normalization path.
package fpaddsub_pkg;

    localparam int MANT_W  = 33;
    localparam int EXP_W   = 8;
    localparam int LZ_W    = 6;
    localparam int SHIFT_W = 4;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              sign;
    } fp_bundle_t;

endpackage

// File: rtl/fpaddsub_normalize_lzd_if.sv
// Handshake and data bundle between the mantissa adder, the normalize stage and the fine shifter.
interface fpaddsub_normalize_lzd_if #(
    parameter int MANT_W  = fpaddsub_pkg::MANT_W,
    parameter int EXP_W   = fpaddsub_pkg::EXP_W,
    parameter int SHIFT_W = fpaddsub_pkg::SHIFT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [MANT_W-1:0]  Sum;
    logic [EXP_W-1:0]   Ein;
    logic               Sin;
    logic               out_valid;
    logic               out_ready;
    logic [MANT_W-1:0]  MminP;
    logic [SHIFT_W-1:0] Shift;
    logic [EXP_W-1:0]   Eout;
    logic               Sout;
    logic               Zero;
    logic               Uflow;

    // Environment side: feeds sums upstream, consumes results downstream.
    modport master (
        output in_valid, Sum, Ein, Sin, out_ready,
        input  in_ready, out_valid, MminP, Shift, Eout, Sout, Zero, Uflow
    );

    modport slave (
        input  in_valid, Sum, Ein, Sin, out_ready,
        output in_ready, out_valid, MminP, Shift, Eout, Sout, Zero, Uflow
    );

endinterface

// File: rtl/fpaddsub_lzc33.sv
// Combinational 33-bit leading-zero counter built from 4-bit priority encoders.
module fpaddsub_lzc33
    import fpaddsub_pkg::*;
(
    input  logic [MANT_W-1:0] sum,
    output logic [LZ_W-1:0]   lz,
    output logic              all_zero
);

    // Returns {found, leading-zero count} for one nibble.
    function automatic logic [2:0] pe4(input logic [3:0] x);
        logic [2:0] r;
        casez (x)
            4'b1???: r = 3'b100;
            4'b01??: r = 3'b101;
            4'b001?: r = 3'b110;
            4'b0001: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [2:0]      nib [8];
    logic [7:0]      nib_v;
    logic [2:0]      grp_hi;
    logic [2:0]      grp_lo;
    logic [2:0]      sel_hi;
    logic [2:0]      sel_lo;
    logic [3:0]      lz_hi;
    logic [3:0]      lz_lo;
    logic [LZ_W-1:0] lz32;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nib[i]   = pe4(sum[4*i+3 -: 4]);
            nib_v[i] = nib[i][2];
        end

        // Second level picks the first non-empty nibble within each 16-bit half.
        grp_hi = pe4(nib_v[7:4]);
        grp_lo = pe4(nib_v[3:0]);
        sel_hi = 3'd7 - {1'b0, grp_hi[1:0]};
        sel_lo = 3'd3 - {1'b0, grp_lo[1:0]};
        lz_hi  = {grp_hi[1:0], nib[sel_hi][1:0]};
        lz_lo  = {grp_lo[1:0], nib[sel_lo][1:0]};

        if (grp_hi[2]) begin
            lz32 = {2'b00, lz_hi};
        end else if (grp_lo[2]) begin
            lz32 = {2'b01, lz_lo};
        end else begin
            lz32 = 6'd32;
        end

        // Bit 32 sits above the 32-bit tree, so everything below it is offset by one.
        lz       = sum[MANT_W-1] ? '0 : lz32 + 6'd1;
        all_zero = !sum[MANT_W-1] && !grp_hi[2] && !grp_lo[2];
    end

endmodule

// File: rtl/fpaddsub_normalize_lzd.sv
// Registered normalize front end: leading-zero count, coarse 0/16/32 left shift, exponent adjust.
module fpaddsub_normalize_lzd #(
    parameter int MANT_W = fpaddsub_pkg::MANT_W,
    parameter int EXP_W  = fpaddsub_pkg::EXP_W,
    parameter int LZ_W   = fpaddsub_pkg::LZ_W
) (
    input  logic                    clk,
    input  logic                    rst,
    fpaddsub_normalize_lzd_if.slave bus
);
    import fpaddsub_pkg::*;

    // Returns {underflow, exponent}; a borrow clamps the exponent to zero.
    function automatic logic [EXP_W:0] exp_adjust(input logic [EXP_W-1:0] e,
                                                  input logic [LZ_W-1:0]  z);
        logic signed [EXP_W:0] diff;
        diff = $signed({1'b0, e}) - $signed({{(EXP_W+1-LZ_W){1'b0}}, z});
        if (diff < 0) begin
            return {1'b1, {EXP_W{1'b0}}};
        end
        return {1'b0, diff[EXP_W-1:0]};
    endfunction

    logic [LZ_W-1:0]    lz;
    logic               all_zero;

    logic [MANT_W-1:0]  mant_p0;
    logic [SHIFT_W-1:0] shift_p0;
    logic [EXP_W-1:0]   exp_p0;
    logic               uflow_p0;

    logic               vld_p1;
    logic [MANT_W-1:0]  mant_p1;
    logic [SHIFT_W-1:0] shift_p1;
    logic [EXP_W-1:0]   exp_p1;
    logic               sign_p1;
    logic               zero_p1;
    logic               uflow_p1;

    fpaddsub_lzc33 u_lzc (
        .sum      (bus.Sum),
        .lz       (lz),
        .all_zero (all_zero)
    );

    // Stage p0: coarse shift and exponent adjust ahead of the output register.
    always_comb begin
        case (lz[LZ_W-1 -: 2])
            2'b00:   mant_p0 = bus.Sum;
            2'b01:   mant_p0 = bus.Sum << 16;
            2'b10:   mant_p0 = bus.Sum << 32;
            default: mant_p0 = '0;
        endcase

        if (all_zero) begin
            shift_p0 = '0;
            exp_p0   = '0;
            uflow_p0 = 1'b0;
        end else begin
            shift_p0             = lz[SHIFT_W-1:0];
            {uflow_p0, exp_p0}   = exp_adjust(bus.Ein, lz);
        end
    end

    assign bus.in_ready = !vld_p1 || bus.out_ready;

    // Stage p1: output register, holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            mant_p1  <= '0;
            shift_p1 <= '0;
            exp_p1   <= '0;
            sign_p1  <= 1'b0;
            zero_p1  <= 1'b0;
            uflow_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                mant_p1  <= mant_p0;
                shift_p1 <= shift_p0;
                exp_p1   <= exp_p0;
                sign_p1  <= bus.Sin;
                zero_p1  <= all_zero;
                uflow_p1 <= uflow_p0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.MminP     = mant_p1;
    assign bus.Shift     = shift_p1;
    assign bus.Eout      = exp_p1;
    assign bus.Sout      = sign_p1;
    assign bus.Zero      = zero_p1;
    assign bus.Uflow     = uflow_p1;

endmodule

// File: tb/tb_fpaddsub_normalize_lzd.sv
// Directed and random checks of the normalize/LZD stage against a bit-scan reference model.
module tb_fpaddsub_normalize_lzd;
    import fpaddsub_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   outs;

    fpaddsub_normalize_lzd_if bus ();

    fpaddsub_normalize_lzd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ref_lz(input logic [MANT_W-1:0] s);
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (s[i]) return MANT_W - 1 - i;
        end
        return MANT_W;
    endfunction

    // Compares the registered outputs against the reference for one accepted vector.
    task automatic expect_vec(input string tag, input fp_bundle_t v);
        int                lz;
        logic [MANT_W-1:0] mm;
        logic [MANT_W-1:0] inv;
        logic [3:0]        sh;
        logic [EXP_W-1:0]  e;
        logic              uf;
        logic              z;
        lz = ref_lz(v.mant);
        z  = (v.mant == '0);
        mm = v.mant << ((lz / 16) * 16);
        sh = z ? 4'd0 : 4'(lz % 16);
        if (z) begin
            e = '0; uf = 1'b0;
        end else if (lz > int'(v.exp)) begin
            e = '0; uf = 1'b1;
        end else begin
            e = EXP_W'(int'(v.exp) - lz); uf = 1'b0;
        end
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".MminP"},     64'(bus.MminP),     64'(mm));
        chk({tag, ".Shift"},     64'(bus.Shift),     64'(sh));
        chk({tag, ".Eout"},      64'(bus.Eout),      64'(e));
        chk({tag, ".Zero"},      64'(bus.Zero),      64'(z));
        chk({tag, ".Uflow"},     64'(bus.Uflow),     64'(uf));
        chk({tag, ".Sout"},      64'(bus.Sout),      64'(v.sign));
        inv = bus.MminP << bus.Shift;
        chk({tag, ".msb_inv"},   64'(bus.Zero ? 1'b1 : inv[MANT_W-1]), 64'd1);
    endtask

    task automatic drive(input fp_bundle_t v);
        bus.in_valid = 1'b1;
        bus.Sum      = v.mant;
        bus.Ein      = v.exp;
        bus.Sin      = v.sign;
    endtask

    // One isolated transfer with downstream always ready.
    task automatic single(input string tag, input fp_bundle_t v);
        bus.out_ready = 1'b1;
        drive(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        expect_vec(tag, v);
        @(posedge clk); #1;
        chk({tag, ".drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    fp_bundle_t bp [4];
    fp_bundle_t rv;
    fp_bundle_t mid;

    initial begin
        passed        = 0;
        total         = 0;
        outs          = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Sum       = '0;
        bus.Ein       = '0;
        bus.Sin       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.MminP",     64'(bus.MminP),     64'd0);
        chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hand-computed directed vectors.
        single("norm", '{mant: 33'h1_0000_0000, exp: 8'd127, sign: 1'b0});
        chk("norm.hand_Eout", 64'(bus.Eout), 64'd127);
        single("coarse_fine", '{mant: 33'h0_0000_8000, exp: 8'd100, sign: 1'b1});
        chk("coarse_fine.hand_MminP", 64'(bus.MminP), 64'h0_8000_0000);
        chk("coarse_fine.hand_Shift", 64'(bus.Shift), 64'd1);
        chk("coarse_fine.hand_Eout",  64'(bus.Eout),  64'd83);
        single("lz32", '{mant: 33'h1, exp: 8'd40, sign: 1'b0});
        chk("lz32.hand_MminP", 64'(bus.MminP), 64'h1_0000_0000);
        chk("lz32.hand_Eout",  64'(bus.Eout),  64'd8);
        single("uflow", '{mant: 33'h1, exp: 8'd20, sign: 1'b0});
        chk("uflow.hand_Uflow", 64'(bus.Uflow), 64'd1);
        chk("uflow.hand_Eout",  64'(bus.Eout),  64'd0);
        single("lz_eq_e", '{mant: 33'h0_0000_8000, exp: 8'd17, sign: 1'b0});
        chk("lz_eq_e.hand_Uflow", 64'(bus.Uflow), 64'd0);
        single("zero", '{mant: 33'h0, exp: 8'd200, sign: 1'b1});
        chk("zero.hand_Zero", 64'(bus.Zero), 64'd1);
        chk("zero.hand_Eout", 64'(bus.Eout), 64'd0);
        single("bit16", '{mant: 33'h0_0001_0000, exp: 8'd255, sign: 1'b0});

        // Reset while a result is stalled at the output.
        mid = '{mant: 33'h0_0000_8000, exp: 8'd100, sign: 1'b1};
        bus.out_ready = 1'b0;
        drive(mid);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid.loaded", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid.MminP",     64'(bus.MminP),     64'd0);
        chk("mid.Eout",      64'(bus.Eout),      64'd0);
        chk("mid.Sout",      64'(bus.Sout),      64'd0);
        chk("mid.Shift",     64'(bus.Shift),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid.in_ready",  64'(bus.in_ready),  64'd1);
        chk("mid.discarded", 64'(bus.out_valid), 64'd0);

        // Back-pressure: four vectors, downstream stalls three cycles after the first.
        bp[0] = '{mant: 33'h1_2345_6789, exp: 8'd10,  sign: 1'b0};
        bp[1] = '{mant: 33'h0_00F0_0000, exp: 8'd50,  sign: 1'b1};
        bp[2] = '{mant: 33'h0_0000_0003, exp: 8'd31,  sign: 1'b0};
        bp[3] = '{mant: 33'h0_4000_0000, exp: 8'd1,   sign: 1'b1};
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(bp[0]);
        @(posedge clk); #1;
        drive(bp[1]);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.stall%0d.in_ready", c), 64'(bus.in_ready), 64'd0);
            expect_vec($sformatf("bp.hold%0d", c), bp[0]);
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            if (k < 3) drive(bp[k+1]);
            else       bus.in_valid = 1'b0;
            expect_vec($sformatf("bp.out%0d", k), bp[k]);
        end
        @(posedge clk); #1;
        chk("bp.drained", 64'(bus.out_valid), 64'd0);

        // Full throughput with random sums spanning all leading-zero counts.
        bus.out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            rv.mant[MANT_W-1]   = 1'($urandom_range(0, 1));
            rv.mant[MANT_W-2:0] = $urandom;
            rv.mant             = rv.mant >> $urandom_range(0, 33);
            rv.exp              = 8'($urandom_range(0, 255));
            rv.sign             = 1'($urandom_range(0, 1));
            drive(rv);
            #1;
            chk($sformatf("tp%0d.in_ready", n), 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            if (bus.out_valid) outs++;
            expect_vec($sformatf("tp%0d", n), rv);
        end
        bus.in_valid = 1'b0;
        chk("tp.count", 64'(outs), 64'd100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpaddsub_normalize_lzd.md
Name: fpaddsub_normalize_lzd

Overview:
- Registered normalization front end of the FP add/sub datapath. It sits directly upstream of the fine normalization shifter (0..15-bit left shift).
- Takes the raw 33-bit mantissa sum and counts its leading zeros. It applies the coarse left shift (0/16/32), adjusts the exponent, and presents the pre-shifted mantissa plus the 4-bit residual shift to the next stage.
- One pipeline register with a valid/ready handshake, so the stage can stall.

Parameters:
- MANT_W, 33, mantissa sum width; bit MANT_W-1 is the normalized MSB position.
- EXP_W, 8, exponent width.
- LZ_W, 6, leading-zero count width; must satisfy 2^LZ_W > MANT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a sum this cycle.
- in_ready  output  1  stage can accept this cycle.
- Sum  input  MANT_W  unnormalized mantissa sum.
- Ein  input  EXP_W  exponent belonging to Sum.
- Sin  input  1  result sign.
- out_valid  output  1  registered outputs are valid.
- out_ready  input  1  downstream accepts this cycle.
- MminP  output  MANT_W  Sum shifted left by 16*LZ[5:4], zero-filled from the LSB.
- Shift  output  4  LZ[3:0]; residual shift for the fine shifter.
- Eout  output  EXP_W  Ein - LZ, saturated at 0.
- Sout  output  1  registered Sin.
- Zero  output  1  Sum was all zeros.
- Uflow  output  1  LZ > Ein; the result is denormal or underflowed.

Behaviour:
- Reset (async, any time):
  - out_valid=0; MminP=0, Shift=0, Eout=0, Sout=0, Zero=0, Uflow=0.
  - An in-flight transfer is discarded.
  - in_ready=1 immediately after reset deassertion.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational; there is no bubble on back-to-back transfers.
  - Accept occurs when in_valid && in_ready at a rising edge. The output register loads, and out_valid becomes 1 in the next cycle.
  - Output transfer occurs when out_valid && out_ready. With no simultaneous accept, out_valid becomes 0.
  - Simultaneous transfer and accept: the register reloads and out_valid stays 1.
  - While out_valid && !out_ready, all outputs hold stable. Changes on Sum/Ein are ignored.
- Latency: exactly 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- LZ computation (combinational, before the register):
  - LZ = count of zeros from bit MANT_W-1 downward until the first 1.
  - LZ = MANT_W (33) when Sum==0.
- Coarse shift:
  - LZ[5:4]=00 -> 0; 01 -> <<16; 10 -> <<32.
  - LZ[5:4]=11 cannot occur for MANT_W=33.
  - Invariant: MminP << Shift has its MSB set, unless Zero=1.
- Zero case (Sum==0): MminP=0, Shift=0, Eout=0, Zero=1, Uflow=0. Sout passes through unchanged.
- Exponent:
  - Eout = Ein - LZ computed in EXP_W+1 bits.
  - On borrow (LZ > Ein): Eout=0 and Uflow=1.
  - LZ == Ein gives Eout=0 with Uflow=0.
- No combinational path from Sum to any output. The only combinational path to in_ready is from out_ready.

Decomposition:
- Shared package fpaddsub_pkg:
  - MANT_W, EXP_W, LZ_W constants.
  - Handshaked bundle typedef {mant, exp, sign}.
- One natural sub-module: fpaddsub_lzc33. It is a purely combinational leading-zero counter (Sum -> LZ[5:0], all_zero), built as a tree of 4-bit priority encoders, and is reusable by the post-rounding renormalizer.
- Shifter, exponent subtract and pipeline register live in the top.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 and all outputs 0 asynchronously; in_ready=1 after release.
- Normalized input: Sum=33'h1_0000_0000, Ein=8'd127 -> MminP=33'h1_0000_0000, Shift=0, Eout=127, Zero=0, Uflow=0, one cycle after accept.
- Coarse plus fine: Sum=33'h0_0000_8000 (LZ=17), Ein=8'd100 -> MminP=33'h0_8000_0000, Shift=1, Eout=83.
- Boundaries:
  - Sum=33'h1, Ein=8'd40 -> MminP=33'h1_0000_0000, Shift=0, LZ=32, Eout=8.
  - Sum=33'h1, Ein=8'd20 -> Eout=0, Uflow=1.
  - Sum=0 -> Zero=1, MminP=0, Shift=0, Eout=0.
- Back-pressure: 4 back-to-back inputs, out_ready held 0 for 3 cycles after the first -> in_ready=0 during the stall, first result held stable, all 4 results emerge in order with no loss or duplicates.
- Full throughput: out_ready=1 and in_valid=1 for 100 cycles of random Sum/Ein -> 100 outputs; each matches the golden model (LZ, MminP, Eout, Uflow) and satisfies the MSB invariant.
